seq_scan_ctrl: RTL
==================

Name: seq_scan_ctrl

Overview:
Controller that sequences a serial 1010 overlapping Mealy detector across a parallel word. On `start` it latches a WORD_W-bit word and feeds it MSB-first, one bit per clock, into the detector. It counts detections and records the bit position of each one. A single-cycle `done` closes each scan. It sits between a register/bus agent and the detector datapath, so software-side logic never drives serial bits directly.

Parameters:
WORD_W, 11, width of scanned word; bits presented index WORD_W-1 down to 0
CNT_W, 4, width of match counter; saturates at 2^CNT_W-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset (0 = reset asserted)
start  in  1  scan request; sampled only in IDLE
word_in  in  WORD_W  word to scan; latched on accepted start
busy  out  1  high while bits are being shifted
done  out  1  one-cycle pulse when scan completes
match_cnt  out  CNT_W  number of detections in last scan, saturating
match_map  out  WORD_W  bit i = 1 if detector fired when word bit i was presented
det_state  out  2  current detector state (debug visibility)

Behaviour:
- Reset (rst=0, async): ctrl FSM=IDLE, detector=S0; busy, done, match_cnt, match_map all 0; index and word regs 0.
- Ctrl FSM, IDLE/SHIFT/DONE:
  - IDLE: if start=1, go to SHIFT, latch word_in, set idx=WORD_W-1, clear match_cnt/match_map, clear detector to S0. Otherwise stay in IDLE.
  - SHIFT: busy=1. Each cycle present word[idx] to the detector. If the detector's Mealy output is 1 that cycle, set match_map[idx]=1 and increment match_cnt, saturating at all-ones. If idx==0, go to DONE; else idx decrements.
  - DONE: busy=0, done=1 for exactly one cycle, then return to IDLE.
- Timing: start accepted at edge 0; bits are consumed at edges 1..WORD_W; done is high the cycle after the last bit; results are valid from done and held until the next accepted start.
- start while busy or in DONE is ignored; it is not queued. start held high in IDLE re-triggers back-to-back scans, one every WORD_W+2 cycles.
- Detector (Mealy, overlapping), states S0=none, S1="1", S2="10", S3="101":
  - S0: in=1 goes to S1; in=0 stays in S0.
  - S1: in=0 goes to S2; in=1 stays in S1.
  - S2: in=1 goes to S3; in=0 goes to S0.
  - S3: in=0 goes to S2 with out=1; in=1 goes to S1.
  - Output is combinational on state and input, qualified by SHIFT. The detector only advances in SHIFT; it holds otherwise.
- Reset mid-scan: immediate return to reset values. No done pulse. Partial results are lost.

Optional Feature:
- Macro SEQ_SCAN_CARRY_EN.
- Defined: the detector is NOT cleared on an accepted start. Its state carries across consecutive words, so a pattern spanning a word boundary is detected and attributed to the bit of the new word on which it completes.
- Undefined: the detector is cleared to S0 on every accepted start; each word is scanned independently.

Decomposition:
- Package seq_scan_pkg:
  - ctrl state typedef (IDLE, SHIFT, DONE)
  - detector state typedef (S0..S3, 2-bit encoding 00/01/10/11)
  - constant for the 1010 target pattern
- One natural sub-module, seq_det_1010_core: the 4-state Mealy detector with ports clk, rst, en, clr, din, dout, state.
- The controller owns the index, counter, map and handshake.

Test Plan:
- Reset then start with word_in=11'b10011010101 → busy high 11 cycles, done 1 cycle later, match_cnt=2, match_map=11'h00A.
- word_in=11'h555 → match_cnt=4, match_map=11'h0AA; rerun with CNT_W=2 → match_cnt saturates at 3, match_map still 11'h0AA.
- word_in=11'h000 and word_in=11'h7FF → match_cnt=0, match_map=0 for both.
- start pulsed during SHIFT with a different word → ignored; results match the first word; done pulses exactly once.
- rst driven low at the 5th SHIFT cycle → busy/done/match_cnt/match_map go to 0 immediately; no done pulse; the next scan of 11'h555 gives the correct result.
- Scan 11'h555 then 11'h000:
  - with SEQ_SCAN_CARRY_EN: the second scan gives match_cnt=1, match_map=11'h400.
  - without the macro: the second scan gives match_cnt=0.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared types and pattern constant for seq_scan_ctrl (optional macro SEQ_SCAN_CARRY_EN used by seq_scan_ctrl)
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_t;
  localparam logic [3:0] PATTERN = 4'b1010;
endpackage

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: scan handshake bus; master drives start/word_in, slave returns busy/done/match_cnt/match_map/det_state
interface seq_scan_ctrl_if #(parameter int WORD_W = 11, parameter int CNT_W = 4);
  logic start;
  logic [WORD_W-1:0] word_in;
  logic busy;
  logic done;
  logic [CNT_W-1:0] match_cnt;
  logic [WORD_W-1:0] match_map;
  logic [1:0] det_state;
  modport master(output start, word_in, input busy, done, match_cnt, match_map, det_state);
  modport slave(input start, word_in, output busy, done, match_cnt, match_map, det_state);
endinterface

// File: rtl/seq_det_1010_core.sv
// seq_det_1010_core: overlapping 1010 Mealy detector; ports clk, rst (async low), en advances, clr sync-clears, din, dout, state
module seq_det_1010_core
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout,
  output det_t state
);
  det_t nx;
  always_comb nx = din ? (state == S2 ? S3 : S1) : (state == S1 || state == S3 ? S2 : S0);
  assign dout = en && state == S3 && din == PATTERN[0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S0;
    else if (clr) state <= S0;
    else if (en) state <= nx;
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans a latched word MSB-first through the 1010 detector; clk, rst (async low), bus (slave); SEQ_SCAN_CARRY_EN keeps detector state across words
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 11,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  seq_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(WORD_W);
  ctrl_t state, state_nx;
  det_t det_q;
  logic [WORD_W-1:0] word, map;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0] idx;
  logic shift, accept, fire, clr;
  assign shift = state == SHIFT;
  assign accept = state == IDLE && bus.start;
`ifdef SEQ_SCAN_CARRY_EN
  assign clr = 1'b0;
`else
  assign clr = accept;
`endif
  always_comb state_nx = accept ? SHIFT : (shift && idx == '0) ? DONE : state == DONE ? IDLE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      word <= '0;
      idx <= '0;
      cnt <= '0;
      map <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        word <= bus.word_in;
        idx <= IW'(WORD_W - 1);
        cnt <= '0;
        map <= '0;
      end else if (shift) begin
        if (idx != '0) idx <= idx - 1'b1;
        if (fire) begin
          map[idx] <= 1'b1;
          cnt <= cnt + CNT_W'(!(&cnt));
        end
      end
    end
  seq_det_1010_core u_det (
    .clk(clk),
    .rst(rst),
    .en(shift),
    .clr(clr),
    .din(word[idx]),
    .dout(fire),
    .state(det_q)
  );
  assign bus.busy = shift;
  assign bus.done = state == DONE;
  assign bus.match_cnt = cnt;
  assign bus.match_map = map;
  assign bus.det_state = det_q;
endmodule
